multicycle_adder: RTL
=====================

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001: WIDTH, 16, operand and result width in bits; SHALL be >= 1.
REQ-002: SEG, 4, bits added per cycle; SHALL divide WIDTH exactly, otherwise elaboration SHALL fail.
REQ-003: Derived constant NSEG = WIDTH/SEG SHALL be the number of segment cycles per operation.
REQ-004: clk  input  1  sole clock; all state changes on rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: start  input  1  request; sampled on every rising edge.
REQ-007: sub  input  1  0 = add, 1 = subtract; sampled with start.
REQ-008: c_in  input  1  carry-in for add mode; ignored when sub=1; sampled with start.
REQ-009: a  input  WIDTH  operand A, unsigned or two's complement; sampled with start.
REQ-010: b  input  WIDTH  operand B; sampled with start.
REQ-011: busy  output  1  high while an operation is in progress.
REQ-012: done  output  1  one-cycle pulse marking valid result.
REQ-013: sum  output  WIDTH  result register.
REQ-014: c_out  output  1  carry out of bit WIDTH-1 (sub mode: 1 = no borrow).
REQ-015: overflow  output  1  signed overflow = carry into MSB XOR c_out.

Function
REQ-016: States SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-017: Start SHALL be accepted on an edge where start=1 and state is IDLE or DONE; accepting SHALL latch a, b, sub, c_in, enter RUN, segment index 0.
REQ-018: Start while in RUN SHALL be ignored, with no effect on latched operands or result.
REQ-019: Add mode SHALL compute a + b + c_in; sub mode SHALL compute a + ~b + 1.
REQ-020: Each RUN cycle SHALL add one SEG-bit segment, LSB segment first, using the carry register from the previous segment; the first segment SHALL use c_in (add) or 1 (sub).
REQ-021: Segment k (0..NSEG-1) SHALL be written into the internal accumulator on edge k+1 after the accepting edge (edge 0).
REQ-022: On edge NSEG the FSM SHALL enter DONE; accumulator, final carry and overflow SHALL be copied to sum, c_out and overflow on that same edge.
REQ-023: busy SHALL be 1 exactly in RUN, i.e. NSEG cycles after the accepting edge.
REQ-024: done SHALL be 1 exactly in DONE, for one cycle; with no new start the FSM SHALL then return to IDLE.
REQ-025: start=1 in DONE SHALL be accepted, giving back-to-back operations with a single done cycle between busy periods.
REQ-026: sum, c_out and overflow SHALL change only on the DONE-entry edge and SHALL hold their value until the next DONE entry; partial results SHALL never be visible.
REQ-027: Operand changes after the accepting edge SHALL not affect the result.
REQ-028: NSEG=1 SHALL be legal: busy for 1 cycle, done on edge 1.
REQ-029: Arithmetic SHALL be modulo 2^WIDTH; overflow SHALL use bit WIDTH-1 as the sign bit.

Reset
REQ-030: reset=1 SHALL force IDLE, busy=0, done=0, sum=0, c_out=0, overflow=0, accumulator, carry and segment index=0 on the next edge.
REQ-031: reset SHALL take priority over start and SHALL abort a RUN in progress, with no done pulse for the aborted operation.
REQ-032: start asserted together with reset SHALL be discarded.

Verification (WIDTH=16, SEG=4 unless noted)
REQ-033: add a=0xFFFF b=0x0001 c_in=0 -> busy 4 cycles; done on edge 4; sum=0x0000, c_out=1, overflow=0.
REQ-034: add a=0x7FFF b=0x0001 c_in=0 -> sum=0x8000, c_out=0, overflow=1; sub a=0x8000 b=0x0001 -> sum=0x7FFF, c_out=1, overflow=1.
REQ-035: add a=0x1234 b=0x1111 c_in=1 with start re-pulsed and operands changed during RUN -> sum=0x2346, c_out=0, exactly one done pulse.
REQ-036: reset asserted at RUN segment 2 -> next edge all outputs 0, no done pulse; a following add 0x0001+0x0001 -> sum=0x0002.
REQ-037: start held high continuously with alternating operand sets -> done every 5th cycle, busy low only in done cycles, each result correct.
REQ-038: WIDTH=8, SEG=8: add 0xFF+0x01 c_in=1 -> done on edge 1, sum=0x01, c_out=1, overflow=0.

Source files
------------

// File: rtl/multicycle_adder.sv
// Multicycle adder/subtractor: adds one SEG-bit slice per cycle, LSB slice first, and
// publishes sum/c_out/overflow only when the last slice completes.
module multicycle_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SEG   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic             c_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int unsigned NSEG = (SEG == 0) ? 1 : WIDTH / SEG;
   localparam int unsigned IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [IDXW-1:0] LastIdx = IDXW'(NSEG - 1);

   if (WIDTH < 1 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_params
      $error("multicycle_adder: SEG must be >= 1 and divide WIDTH exactly");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              c_out_q, c_out_d;
   logic              ovf_q, ovf_d;

   logic [SEG-1:0]    a_seg;
   logic [SEG-1:0]    b_seg;
   logic [SEG:0]      seg_sum;
   logic              msb_cin;
   logic [31:0]       seg_lsb;

   // b_q holds the already-conditioned operand (inverted for subtract), so the slice adder
   // never needs to know the mode.
   always_comb begin
      seg_lsb = 32'(idx_q) * SEG;
      a_seg   = a_q[seg_lsb +: SEG];
      b_seg   = b_q[seg_lsb +: SEG];
      seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, carry_q};
      // Carry into the slice MSB recovered from its sum bit; on the last slice this is the
      // carry into bit WIDTH-1.
      msb_cin = a_seg[SEG-1] ^ b_seg[SEG-1] ^ seg_sum[SEG-1];
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StRun;
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : c_in;
               idx_d   = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            acc_d[seg_lsb +: SEG] = seg_sum[SEG-1:0];
            carry_d               = seg_sum[SEG];
            if (idx_q == LastIdx) begin
               state_d = StDone;
               idx_d   = '0;
               sum_d   = acc_d;
               c_out_d = seg_sum[SEG];
               ovf_d   = msb_cin ^ seg_sum[SEG];
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy     = (state_q == StRun);
   assign done     = (state_q == StDone);
   assign sum      = sum_q;
   assign c_out    = c_out_q;
   assign overflow = ovf_q;

endmodule
